// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the writeback arbiter: the
//               queued result entry, FU indices and the round-robin helper.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int NUM_FU      = 3;
    localparam int BCAST_WIDTH = 2;

    localparam int FU_ALU0 = 0;
    localparam int FU_ALU1 = 1;
    localparam int FU_LSU  = 2;

    localparam int PREG_W = 6;
    localparam int DATA_W = 32;
    localparam int ROB_W  = 6;

    typedef struct packed {
        logic              has_rd;
        logic [PREG_W-1:0] preg;
        logic [DATA_W-1:0] data;
        logic [ROB_W-1:0]  rob;
    } wb_entry_t;

    // Next FU index in round-robin order, wrapping after the LSU.
    function automatic logic [1:0] wb_next_fu(input logic [1:0] idx);
        return (idx == 2'(FU_LSU)) ? 2'(FU_ALU0) : idx + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_result_fifo
// Description : Per-FU result queue. Power-of-two depth, no pass-through;
//               pushes while full and pops while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_entry_t                push_data,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   c_cnt_one  = (AW+1)'(1);
    localparam logic [AW:0]   c_cnt_full = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_ptr_one  = AW'(1);

    wb_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == c_cnt_full);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : writeback_arbiter
// Description : Buffers results from ALU0/ALU1/LSU, broadcasts up to two per
//               cycle round-robin, and owns the physical-register ready table.
//               Optional macro WB_BYPASS_EN lets a result on an empty queue
//               skip the queue when it wins arbitration (1-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int PREG_COUNT  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_FU-1:0]       fu_valid,
    input  logic [NUM_FU-1:0]       fu_has_rd,
    input  logic [5:0]              fu_preg     [0:2],
    input  logic [31:0]             fu_data     [0:2],
    input  logic [5:0]              fu_rob      [0:2],
    output logic [NUM_FU-1:0]       fu_ready,
    input  logic [1:0]              alloc_valid,
    input  logic [5:0]              alloc_preg  [0:1],
    output logic [BCAST_WIDTH-1:0]  bcast_valid,
    output logic [BCAST_WIDTH-1:0]  bcast_we,
    output logic [5:0]              bcast_preg  [0:1],
    output logic [31:0]             bcast_data  [0:1],
    output logic [5:0]              bcast_rob   [0:1],
    output logic [PREG_COUNT-1:0]   reg_ready
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    wb_entry_t              w_in_entry [NUM_FU];
    wb_entry_t              w_head     [NUM_FU];
    logic [CNT_W-1:0]       w_count    [NUM_FU];
    logic [NUM_FU-1:0]      w_full;
    logic [NUM_FU-1:0]      w_empty;
    logic [NUM_FU-1:0]      w_nonempty;
    logic [NUM_FU-1:0]      w_elig;
    logic [NUM_FU-1:0]      w_gnt;
    logic [NUM_FU-1:0]      w_push;
    logic [NUM_FU-1:0]      w_pop;
    logic [1:0]             r_ptr;
    logic [1:0]             w_ptr_nxt;
    logic [1:0]             w_i1;
    logic [1:0]             w_i2;
    logic [BCAST_WIDTH-1:0] w_slot_vld;
    logic [1:0]             w_slot_idx [BCAST_WIDTH];
    wb_entry_t              w_slot_ent [BCAST_WIDTH];
    logic [BCAST_WIDTH-1:0] w_slot_we;
    logic [PREG_COUNT-1:0]  w_ready_nxt;

    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
        assign w_in_entry[gi] = '{has_rd: fu_has_rd[gi], preg: fu_preg[gi],
                                  data: fu_data[gi], rob: fu_rob[gi]};
        assign w_nonempty[gi] = (w_count[gi] != '0);

        wb_result_fifo #(
            .DEPTH     (QUEUE_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (w_push[gi]),
            .push_data (w_in_entry[gi]),
            .pop       (w_pop[gi]),
            .head      (w_head[gi]),
            .full      (w_full[gi]),
            .empty     (w_empty[gi]),
            .count     (w_count[gi])
        );
    end

    // No pass-through at full: ready depends only on registered occupancy.
    assign fu_ready = ~w_full;

    // Which FUs compete this cycle: queued heads, plus bypassable inputs.
    always_comb begin
        w_elig = w_nonempty;
`ifdef WB_BYPASS_EN
        w_elig = w_nonempty | (fu_valid & fu_ready);
`endif
    end

    // Round-robin scan from r_ptr, granting the first two eligible FUs.
    always_comb begin
        w_i1          = wb_next_fu(r_ptr);
        w_i2          = wb_next_fu(w_i1);
        w_slot_vld    = '0;
        w_slot_idx[0] = r_ptr;
        w_slot_idx[1] = r_ptr;
        if (w_elig[r_ptr]) begin
            w_slot_vld[0] = 1'b1;
            w_slot_idx[0] = r_ptr;
            if (w_elig[w_i1]) begin
                w_slot_vld[1] = 1'b1;
                w_slot_idx[1] = w_i1;
            end else if (w_elig[w_i2]) begin
                w_slot_vld[1] = 1'b1;
                w_slot_idx[1] = w_i2;
            end
        end else if (w_elig[w_i1]) begin
            w_slot_vld[0] = 1'b1;
            w_slot_idx[0] = w_i1;
            if (w_elig[w_i2]) begin
                w_slot_vld[1] = 1'b1;
                w_slot_idx[1] = w_i2;
            end
        end else if (w_elig[w_i2]) begin
            w_slot_vld[0] = 1'b1;
            w_slot_idx[0] = w_i2;
        end

        if (w_slot_vld[1])      w_ptr_nxt = wb_next_fu(w_slot_idx[1]);
        else if (w_slot_vld[0]) w_ptr_nxt = wb_next_fu(w_slot_idx[0]);
        else                    w_ptr_nxt = r_ptr;

        w_gnt = '0;
        for (int s = 0; s < BCAST_WIDTH; s++) begin
            if (w_slot_vld[s]) w_gnt[w_slot_idx[s]] = 1'b1;
        end
    end

    // Select each slot's payload; preg 0 never writes back.
    always_comb begin
        for (int s = 0; s < BCAST_WIDTH; s++) begin
            w_slot_ent[s] = w_head[w_slot_idx[s]];
`ifdef WB_BYPASS_EN
            if (!w_nonempty[w_slot_idx[s]]) w_slot_ent[s] = w_in_entry[w_slot_idx[s]];
`endif
            w_slot_we[s] = w_slot_vld[s] & w_slot_ent[s].has_rd & (w_slot_ent[s].preg != '0);
        end
    end

    // Queue control: pop granted heads, push accepted results not bypassed.
    always_comb begin
        w_pop  = w_gnt & w_nonempty;
        w_push = fu_valid & fu_ready;
`ifdef WB_BYPASS_EN
        w_push = fu_valid & fu_ready & ~(w_gnt & ~w_nonempty);
`endif
    end

    // Ready table: broadcasts set first, then dispatch clears override.
    always_comb begin
        w_ready_nxt = reg_ready;
        for (int s = 0; s < BCAST_WIDTH; s++) begin
            if (w_slot_we[s]) w_ready_nxt[w_slot_ent[s].preg] = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            if (alloc_valid[k] && (alloc_preg[k] != '0)) w_ready_nxt[alloc_preg[k]] = 1'b0;
        end
    end

    // Broadcast registers, ready table and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            reg_ready   <= '1;
            bcast_valid <= '0;
            bcast_we    <= '0;
            for (int s = 0; s < BCAST_WIDTH; s++) begin
                bcast_preg[s] <= '0;
                bcast_data[s] <= '0;
                bcast_rob[s]  <= '0;
            end
        end else begin
            r_ptr       <= w_ptr_nxt;
            reg_ready   <= w_ready_nxt;
            bcast_valid <= w_slot_vld;
            bcast_we    <= w_slot_we;
            for (int s = 0; s < BCAST_WIDTH; s++) begin
                if (w_slot_vld[s]) begin
                    bcast_preg[s] <= w_slot_ent[s].preg;
                    bcast_data[s] <= w_slot_ent[s].data;
                    bcast_rob[s]  <= w_slot_ent[s].rob;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // FU must not present a result while its queue is full; never pop empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                assert (!(fu_valid[i] && !fu_ready[i]));
                assert (!(w_pop[i] && w_empty[i]));
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_arbiter
// Description : Self-checking bench for writeback_arbiter: directed cases plus
//               random traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_writeback_arbiter;

    localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  fu_valid, fu_has_rd, fu_ready;
    logic [5:0]  fu_preg [0:2];
    logic [31:0] fu_data [0:2];
    logic [5:0]  fu_rob  [0:2];
    logic [1:0]  alloc_valid;
    logic [5:0]  alloc_preg [0:1];
    logic [1:0]  bcast_valid, bcast_we;
    logic [5:0]  bcast_preg [0:1];
    logic [31:0] bcast_data [0:1];
    logic [5:0]  bcast_rob  [0:1];
    logic [63:0] reg_ready;

    always #5 clk = ~clk;

    writeback_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .fu_valid    (fu_valid),
        .fu_has_rd   (fu_has_rd),
        .fu_preg     (fu_preg),
        .fu_data     (fu_data),
        .fu_rob      (fu_rob),
        .fu_ready    (fu_ready),
        .alloc_valid (alloc_valid),
        .alloc_preg  (alloc_preg),
        .bcast_valid (bcast_valid),
        .bcast_we    (bcast_we),
        .bcast_preg  (bcast_preg),
        .bcast_data  (bcast_data),
        .bcast_rob   (bcast_rob),
        .reg_ready   (reg_ready)
    );

    typedef struct packed {
        logic        has_rd;
        logic [5:0]  preg;
        logic [31:0] data;
        logic [5:0]  rob;
    } ent_t;

    // Reference model state
    ent_t        mq [3][$];
    int          m_ptr;
    logic [63:0] m_ready;
    logic [1:0]  e_valid, e_we;
    ent_t        e_ent [2];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [5:0]  rob_ctr  = '0;
    logic        seen_not_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        fu_valid    = '0;
        fu_has_rd   = '0;
        alloc_valid = '0;
        for (int i = 0; i < 3; i++) begin
            fu_preg[i] = '0;
            fu_data[i] = '0;
            fu_rob[i]  = '0;
        end
        alloc_preg[0] = '0;
        alloc_preg[1] = '0;
    endtask

    task automatic set_push(input int i, input logic has_rd, input logic [5:0] preg,
                            input logic [31:0] data, input logic [5:0] rob);
        fu_valid[i]  = 1'b1;
        fu_has_rd[i] = has_rd;
        fu_preg[i]   = preg;
        fu_data[i]   = data;
        fu_rob[i]    = rob;
    endtask

    // Advance the model for the inputs now applied, clock once, compare.
    task automatic step();
        bit   rdy_pre [3];
        bit   elig    [3];
        bit   byp     [3];
        int   gi      [2];
        int   ng;
        ent_t in_e    [3];
        ent_t en;
        for (int i = 0; i < 3; i++) begin
            rdy_pre[i] = (mq[i].size() < DEPTH);
            check($sformatf("fu_ready%0d", i), 64'(fu_ready[i]), 64'(rdy_pre[i]));
            in_e[i] = {fu_has_rd[i], fu_preg[i], fu_data[i], fu_rob[i]};
            byp[i]  = 1'b0;
        end
        if (rst) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            m_ptr   = 0;
            m_ready = '1;
            e_valid = '0;
            e_we    = '0;
        end else begin
            ng = 0;
            gi[0] = 0;
            gi[1] = 0;
            for (int i = 0; i < 3; i++) elig[i] = (mq[i].size() > 0) || (BYP && fu_valid[i]);
            for (int k = 0; k < 3; k++) begin
                int idx;
                idx = (m_ptr + k) % 3;
                if (elig[idx] && ng < 2) begin
                    gi[ng] = idx;
                    ng++;
                end
            end
            e_valid = '0;
            e_we    = '0;
            for (int s = 0; s < ng; s++) begin
                if (mq[gi[s]].size() > 0) begin
                    en = mq[gi[s]].pop_front();
                end else begin
                    en = in_e[gi[s]];
                    byp[gi[s]] = 1'b1;
                end
                e_ent[s]   = en;
                e_valid[s] = 1'b1;
                e_we[s]    = en.has_rd && (en.preg != 0);
            end
            if (ng > 0) m_ptr = (gi[ng-1] + 1) % 3;
            for (int i = 0; i < 3; i++)
                if (fu_valid[i] && rdy_pre[i] && !byp[i]) mq[i].push_back(in_e[i]);
            for (int s = 0; s < 2; s++)
                if (e_valid[s] && e_we[s]) m_ready[e_ent[s].preg] = 1'b1;
            for (int k = 0; k < 2; k++)
                if (alloc_valid[k] && alloc_preg[k] != 0) m_ready[alloc_preg[k]] = 1'b0;
        end
        @(posedge clk);
        #1;
        check("bcast_valid", 64'(bcast_valid), 64'(e_valid));
        for (int s = 0; s < 2; s++) begin
            if (e_valid[s]) begin
                check($sformatf("bcast_we%0d", s),   64'(bcast_we[s]),   64'(e_we[s]));
                check($sformatf("bcast_preg%0d", s), 64'(bcast_preg[s]), 64'(e_ent[s].preg));
                check($sformatf("bcast_data%0d", s), 64'(bcast_data[s]), 64'(e_ent[s].data));
                check($sformatf("bcast_rob%0d", s),  64'(bcast_rob[s]),  64'(e_ent[s].rob));
            end
        end
        check("reg_ready", reg_ready, m_ready);
    endtask

    // Idle-step until slot 0 broadcasts, with a bounded wait.
    task automatic wait_bcast();
        int n;
        n = 0;
        while (!bcast_valid[0] && n < 4) begin
            step();
            n++;
        end
        check("bcast_timeout", 64'(bcast_valid[0]), 64'd1);
    endtask

    task automatic drain();
        idle_inputs();
        repeat (8) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        m_ptr   = 0;
        m_ready = '1;
        e_valid = '0;
        e_we    = '0;
        step();
        rst = 1'b0;

        // Reset state, then idle
        check("rst_reg_ready", reg_ready, 64'hFFFF_FFFF_FFFF_FFFF);
        check("rst_bcast_valid", 64'(bcast_valid), 64'd0);
        check("rst_fu_ready", 64'(fu_ready), 64'd7);
        repeat (3) step();
        check("idle_reg_ready", reg_ready, 64'hFFFF_FFFF_FFFF_FFFF);
        check("idle_bcast_valid", 64'(bcast_valid), 64'd0);
        check("idle_fu_ready", 64'(fu_ready), 64'd7);

        // Allocation clears, broadcast sets with the expected latency
        alloc_valid = 2'b01;
        alloc_preg[0] = 6'd12;
        step();
        idle_inputs();
        check("alloc12_clear", 64'(reg_ready[12]), 64'd0);
        set_push(0, 1'b1, 6'd12, 32'h1234, 6'd5);
        step();
        idle_inputs();
`ifndef WB_BYPASS_EN
        check("latency_not_early", 64'(bcast_valid), 64'd0);
        step();
`endif
        check("p12_valid", 64'(bcast_valid[0]), 64'd1);
        check("p12_preg", 64'(bcast_preg[0]), 64'd12);
        check("p12_data", 64'(bcast_data[0]), 64'h1234);
        check("p12_rob", 64'(bcast_rob[0]), 64'd5);
        check("p12_we", 64'(bcast_we[0]), 64'd1);
        check("p12_ready", 64'(reg_ready[12]), 64'd1);
        drain();

        // Flood: all FUs push whenever ready
        seen_not_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (fu_ready != 3'b111) seen_not_ready = 1'b1;
                fu_valid[i]  = (mq[i].size() < DEPTH);
                fu_has_rd[i] = 1'b1;
                fu_preg[i]   = 6'($urandom_range(1, 63));
                fu_data[i]   = $urandom;
                fu_rob[i]    = rob_ctr;
                rob_ctr      = rob_ctr + 6'd1;
            end
            step();
            if (c >= 1) check("flood_two_bcast", 64'(bcast_valid), 64'd3);
        end
        check("flood_fu_ready_drop", 64'(seen_not_ready), 64'd1);
        drain();

        // Clear wins over a same-cycle set of the same preg
        set_push(0, 1'b1, 6'd20, 32'hABCD, 6'd7);
`ifdef WB_BYPASS_EN
        alloc_valid = 2'b10;
        alloc_preg[1] = 6'd20;
`endif
        step();
        idle_inputs();
`ifndef WB_BYPASS_EN
        alloc_valid = 2'b10;
        alloc_preg[1] = 6'd20;
        step();
        idle_inputs();
`endif
        check("clr_wins_valid", 64'(bcast_valid[0]), 64'd1);
        check("clr_wins_we", 64'(bcast_we[0]), 64'd1);
        check("clr_wins_ready20", 64'(reg_ready[20]), 64'd0);
        drain();

        // has_rd = 0: ROB completion only
        alloc_valid = 2'b01;
        alloc_preg[0] = 6'd33;
        step();
        idle_inputs();
        set_push(2, 1'b0, 6'd33, 32'h55, 6'd9);
        step();
        idle_inputs();
        wait_bcast();
        check("nord_we", 64'(bcast_we[0]), 64'd0);
        check("nord_rob", 64'(bcast_rob[0]), 64'd9);
        check("nord_ready33", 64'(reg_ready[33]), 64'd0);
        drain();

        // has_rd with preg 0 never writes
        set_push(1, 1'b1, 6'd0, 32'h77, 6'd10);
        step();
        idle_inputs();
        wait_bcast();
        check("p0_we", 64'(bcast_we[0]), 64'd0);
        check("p0_rob", 64'(bcast_rob[0]), 64'd10);
        check("p0_ready0", 64'(reg_ready[0]), 64'd1);
        drain();

        // Random traffic
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 3; i++) begin
                fu_valid[i]  = ($urandom_range(0, 2) != 0) && (mq[i].size() < DEPTH);
                fu_has_rd[i] = ($urandom_range(0, 3) != 0);
                fu_preg[i]   = 6'($urandom_range(0, 63));
                fu_data[i]   = $urandom;
                fu_rob[i]    = rob_ctr;
                rob_ctr      = rob_ctr + 6'd1;
            end
            alloc_valid   = 2'($urandom_range(0, 3));
            alloc_preg[0] = 6'($urandom_range(0, 63));
            alloc_preg[1] = 6'($urandom_range(0, 63));
            step();
        end
        idle_inputs();

        // Reset with entries queued
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 3; i++)
                set_push(i, 1'b1, 6'($urandom_range(1, 63)), $urandom, 6'(40 + 3 * c + i));
            step();
        end
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_bcast_valid", 64'(bcast_valid), 64'd0);
        check("midrst_ready", reg_ready, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        check("postrst_bcast_valid", 64'(bcast_valid), 64'd0);
        check("postrst_fu_ready", 64'(fu_ready), 64'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_arbiter.md
# writeback_arbiter

Collects completed results from the three functional units (FU0 = ALU0, FU1 = ALU1, FU2 = LSU), buffers them per unit, and broadcasts up to two per cycle on the result bus. The result bus feeds the dirty register file, ROB completion and reservation-station wakeup. The block owns the 64-entry physical-register ready table consumed by the reservation station: dispatch clears bits, broadcast sets them. It is the producer side of the ready/forwarding interface and the consumer side of FU issue.

## Interface
- QUEUE_DEPTH, 4: entries per FU result queue; power of two, at least 2.
- PREG_COUNT, 64: physical registers; preg index width is 6.
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- fu_valid  input  3  result present from FU i.
- fu_has_rd  input  3  result writes a preg; 0 for sw/branch.
- fu_preg[0:2]  input  6  destination preg.
- fu_data[0:2]  input  32  result value.
- fu_rob[0:2]  input  6  ROB row of the instruction.
- fu_ready  output  3  FU i may present a result; equals queue i not full.
- alloc_valid  input  2  dispatch slot allocates a destination preg.
- alloc_preg[0:1]  input  6  preg being allocated.
- bcast_valid  output  2  broadcast slot valid (registered).
- bcast_we  output  2  slot writes the regfile and sets ready.
- bcast_preg[0:1], bcast_data[0:1], bcast_rob[0:1]  output  6/32/6  broadcast payload (registered).
- reg_ready  output  64  ready table (registered).

## Operation
- Reset values:
  - queues empty and fu_ready = 3'b111;
  - bcast_valid = 0, bcast_we = 0, payloads 0;
  - reg_ready = all ones;
  - round-robin pointer = 0.
- Push: on fu_valid[i] && fu_ready[i], append {has_rd, preg, data, rob} to queue i.
- Full queue: fu_ready[i] = 0 even if a pop occurs in the same cycle. There is no pass-through at full.
- A push with fu_ready low is an FU protocol violation. The result is dropped; an assertion fires.
- Arbitration, every cycle:
  - scan queue heads starting at the pointer, in order p, p+1, p+2 (mod 3);
  - grant the first two non-empty heads, to slot 0 then slot 1;
  - pop the granted heads;
  - move the pointer to (last granted index + 1) mod 3;
  - if nothing is granted, the pointer holds.
- Granted entries load the bcast registers. Slots without a grant get bcast_valid = 0.
- Ready table, per clock edge, in order:
  1. set reg_ready[preg] for each granted entry with has_rd = 1;
  2. clear reg_ready[alloc_preg[k]] for each alloc_valid[k].
  - A clear wins over a set of the same preg in the same cycle.
  - Preg 0 is never cleared and never broadcast with bcast_we = 1; has_rd with preg 0 is forced to we = 0.
- Entries with has_rd = 0 still broadcast, with bcast_we = 0, for ROB completion only.
- Reset mid-operation: all queued results are discarded and the table returns to all ones. The pipeline flush is handled by the ROB.

## Timing
- Without WB_BYPASS_EN:
  - a result accepted at edge N is eligible for arbitration in the cycle after edge N;
  - earliest broadcast is visible after edge N+1 (2-cycle latency);
  - reg_ready updates at that same edge.
- Throughput: 2 broadcasts per cycle sustained, with 3 pushes per cycle offered.
- No starvation: a non-empty queue is granted within 2 cycles.
- fu_ready is combinational from the registered queue counts.

## Configuration
- WB_BYPASS_EN defined:
  - an FU whose queue is empty and whose input wins arbitration bypasses the queue and loads the bcast registers at edge N (1-cycle latency);
  - arbitration then treats a valid input on an empty queue as a non-empty head.
- WB_BYPASS_EN undefined: every result passes through its queue.

## Structure
- Shared package wb_pkg:
  - typedef wb_entry_t {has_rd, preg[5:0], data[31:0], rob[5:0]};
  - constants NUM_FU = 3, BCAST_WIDTH = 2, FU_ALU0/FU_ALU1/FU_LSU indices.
- One sub-module, wb_result_fifo (parameterized depth, wb_entry_t payload, full/empty/count), instantiated three times.
- Arbiter, ready table and bcast registers live in writeback_arbiter.

## Test plan
- Reset, then idle 3 cycles:
  - reg_ready = 64'hFFFF_FFFF_FFFF_FFFF, bcast_valid = 0, fu_ready = 3'b111.
- alloc_preg[0] = 12:
  - next cycle reg_ready[12] = 0;
  - FU0 pushes preg 12, data 32'h1234, rob 5;
  - two edges later: bcast_valid[0] = 1, bcast_preg[0] = 12, data 32'h1234, we = 1, reg_ready[12] = 1.
- All three FUs push every cycle for 10 cycles:
  - 2 broadcasts per cycle;
  - grant order rotates 0,1 / 2,0 / 1,2;
  - fu_ready deasserts when a queue reaches 4;
  - no result lost or duplicated (scoreboard on rob).
- Same cycle: broadcast of preg 20 and alloc_preg 20 → reg_ready[20] = 0 after the edge.
- FU2 pushes has_rd = 0, rob 9 → broadcast with we = 0, rob 9; reg_ready unchanged. Push of has_rd = 1, preg 0 → we = 0.
- With WB_BYPASS_EN, FU1 push into an empty queue at edge N → bcast valid after edge N. Assert rst with 3 entries queued → next cycle queues empty and bcast_valid = 0.
